// File: rtl/mul_partial_combine.sv
// rtl/mul_partial_combine.sv - two-stage elastic combiner forming the low 32 bits of a 32x32 product
module mul_partial_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_p1_q, s1_p1_d;
  logic [15:0]      s1_mid_q, s1_mid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic s1_move;
  logic consume;

  // Handshake: S2 frees when empty or drained; S1 frees when empty or moving on
  always_comb begin
    s2_adv   = ~out_valid_q | out_ready;
    s1_adv   = ~s1_valid_q | s2_adv;
    in_ready = s1_adv & ~flush;
    accept   = in_valid & in_ready;
    s1_move  = s1_valid_q & s2_adv;
    consume  = out_valid_q & out_ready;
  end

  // Next-state: valid bits follow transfers (flush wins); data loads only on advance
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_p1_d      = s1_p1_q;
    s1_mid_d     = s1_mid_q;
    s1_tag_d     = s1_tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;

    if (accept) begin
      s1_p1_d  = in_p1;
      // Upper halves of p2/p3 land above bit 31 of the product, so only the low halves matter
      s1_mid_d = in_p2[15:0] + in_p3[15:0];
      s1_tag_d = in_tag;
    end

    if (s1_move) begin
      out_result_d = s1_p1_q + {s1_mid_q, 16'h0000};
      out_tag_d    = s1_tag_q;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept)       s1_valid_d = 1'b1;
      else if (s1_move) s1_valid_d = 1'b0;

      if (s1_move)      out_valid_d = 1'b1;
      else if (consume) out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_p1_q      <= '0;
      s1_mid_q     <= '0;
      s1_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_p1_q      <= s1_p1_d;
      s1_mid_q     <= s1_mid_d;
      s1_tag_q     <= s1_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_mul_partial_combine.sv
// tb/tb_mul_partial_combine.sv - scoreboard bench for mul_partial_combine
module tb_mul_partial_combine;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_p1, in_p2, in_p3;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [36:0] exp_q[$];

  logic             stalled_prev = 1'b0;
  logic [31:0]      held_result;
  logic [TAG_W-1:0] held_tag;
  int               in_ready_low_cnt = 0;

  mul_partial_combine #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] p1, input logic [31:0] p2,
                                        input logic [31:0] p3);
    logic [15:0] mid;
    mid = p2[15:0] + p3[15:0];
    return p1 + {mid, 16'h0000};
  endfunction

  // Monitor: pops the scoreboard on every consumed result and checks stall stability
  always @(negedge clk) begin
    if (!reset && !flush) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_output: got tag %0d result 0x%08h expected none", out_tag, out_result);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("out_result", out_result, e[31:0]);
          chk("out_tag", 32'(out_tag), 32'(e[36:32]));
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled_prev) begin
          chk("stall_result_stable", out_result, held_result);
          chk("stall_tag_stable", 32'(out_tag), 32'(held_tag));
        end
        held_result  = out_result;
        held_tag     = out_tag;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (!in_ready) in_ready_low_cnt++;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Drive one input (called just after a posedge); optionally record its expected result
  task automatic send(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                      input logic [TAG_W-1:0] tag, input bit expect_out,
                      input logic [31:0] exp_res);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_p1    = p1;
    in_p2    = p2;
    in_p3    = p3;
    in_tag   = tag;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        if (expect_out) exp_q.push_back({tag, exp_res});
        done = 1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: tag %0d never accepted within 200 cycles", tag);
    end
  endtask

  initial begin
    int c0;
    logic [31:0] r1, r2, r3;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    // Basic product with latency and single-cycle valid
    send(32'h0000_0008, 32'h0000_0006, 32'h0000_0004, 5'd3, 1, 32'h000A_0008);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_valid", 32'(out_valid), 32'd1);
    @(negedge clk); chk("lat_one_cycle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Wrap-around and ignored upper halves
    send(32'h1234_5678, 32'h0000_FFFF, 32'h0000_0001, 5'd4, 1, 32'h1234_5678);
    send(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd5, 1, 32'h0000_FFFF);
    send(32'h0BAD_F00D, 32'hABCD_0000, 32'h0000_0000, 5'd6, 1, 32'h0BAD_F00D);
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Back-pressure: tags 1..6 back-to-back, out_ready low for four cycles
    in_ready_low_cnt = 0;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          logic [31:0] a, b, c;
          a = 32'h0101_0101 * t; b = 32'h0000_1000 * t; c = 32'h0000_0111 * t;
          send(a, b, c, 5'(t), 1, model(a, b, c));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk); #1 out_ready = 1'b0;
        repeat (4) @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    compared++;
    if (in_ready_low_cnt == 0) begin
      mismatched++;
      $display("FAIL backpressure_in_ready: got 0 low cycles expected at least 1");
    end
    repeat (4) @(posedge clk); #1;

    // Full throughput: 16 random inputs accepted in 16 cycles
    c0 = cyc;
    for (int k = 0; k < 16; k++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      send(r1, r2, r3, 5'(k + 8), 1, model(r1, r2, r3));
    end
    in_valid = 1'b0;
    chk("throughput_cycles", 32'(cyc - c0), 32'd16);
    repeat (4) @(posedge clk); #1;

    // Flush with both stages full and a simultaneous input/consume
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h1, 32'h1, 5'd20, 0, 32'h0);
    send(32'h2222_2222, 32'h2, 32'h2, 5'd21, 0, 32'h0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_p1 = 32'h3333_3333; in_tag = 5'd22;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("flush_no_accept", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset while two entries are held
    out_ready = 1'b0;
    send(32'h4444_4444, 32'h4, 32'h4, 5'd23, 0, 32'h0);
    send(32'h5555_5555, 32'h5, 32'h5, 5'd24, 0, 32'h0);
    in_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_out_result", out_result, 32'h0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0008, 32'h0000_0006, 32'h0000_0004, 5'd3, 1, 32'h000A_0008);
    in_valid = 1'b0;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
